// File: rtl/stopwatch_pkg.sv
// Shared definitions for the MM:SS stopwatch: FSM encodings, default clock rate and the
// debounce-length helper.
package stopwatch_pkg;

  // Default main clock; the display scanner derives its refresh rate from this as well.
  localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;

  // Encodings are exported on the status LEDs, so they are fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } sw_state_e;

  // Clock cycles a button level must stay stable before it is accepted.
  function automatic int unsigned deb_cycles(input int unsigned clk_hz,
                                             input int unsigned debounce_ms);
    return clk_hz / 1000 * debounce_ms;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Debouncer for one raw push-button: 2-FF synchronizer, stability counter, and a one-cycle
// pulse on each accepted press. Releases produce no pulse.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic          press_q;

  // Count consecutive synchronized samples that disagree with the accepted level; the
  // DEB_CYCLES-th such sample flips the level. Any agreeing sample restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchronizer, debounce state and registered rising-edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= 2'b00;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], btn};
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounces start/pause/lap, runs the IDLE/RUN/PAUSE FSM and
// the 1 Hz prescaler, and drives counter clear, second tick, lap capture and display select.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ      = CLK_HZ_DEFAULT,
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_lap,
  output logic       cnt_clr,
  output logic       sec_tick,
  output logic       lap_latch,
  output logic       disp_sel,
  output logic [1:0] state
);

  localparam int unsigned DEB_CYCLES = deb_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);

  logic      start_ev, pause_ev, lap_ev;
  sw_state_e state_q;
  logic [PW-1:0] pre_q;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_start),
    .press (start_ev)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_pause),
    .press (pause_ev)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_lap),
    .press (lap_ev)
  );

  // FSM, prescaler and registered output pulses. Event priority is start > pause > lap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      cnt_clr   <= 1'b0;
      sec_tick  <= 1'b0;
      lap_latch <= 1'b0;
      disp_sel  <= 1'b0;
    end else begin
      cnt_clr   <= 1'b0;
      sec_tick  <= 1'b0;
      lap_latch <= 1'b0;

      // Prescaler only advances in RUN; PAUSE holds it so the fractional second survives.
      if (state_q == ST_RUN) begin
        if (pre_q == PRE_LAST) begin
          pre_q    <= '0;
          sec_tick <= 1'b1;
        end else begin
          pre_q <= pre_q + PW'(1);
        end
      end

      unique case (state_q)
        ST_IDLE: begin
          if (start_ev) begin
            state_q <= ST_RUN;
            cnt_clr <= 1'b1;
          end
        end
        ST_RUN: begin
          if (start_ev) begin
            cnt_clr <= 1'b1;
          end else if (pause_ev) begin
            state_q <= ST_PAUSE;
          end else if (lap_ev) begin
            if (!disp_sel) begin
              lap_latch <= 1'b1;
            end
            disp_sel <= ~disp_sel;
          end
        end
        ST_PAUSE: begin
          if (start_ev) begin
            state_q <= ST_IDLE;
            cnt_clr <= 1'b1;
          end else if (pause_ev) begin
            state_q <= ST_RUN;
          end else if (lap_ev && disp_sel) begin
            disp_sel <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // A start press clears in every state; the clear wins over a coinciding tick.
      if (start_ev) begin
        pre_q    <= '0;
        sec_tick <= 1'b0;
        disp_sel <= 1'b0;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with a 10 kHz clock and 1 ms debounce.
module tb_stopwatch_ctrl;

  localparam int unsigned CLK_HZ      = 10_000;
  localparam int unsigned DEBOUNCE_MS = 1;
  // Edges from driving a button to the consuming FSM edge: 2 sync + 10 stable + 1 edge + 1 FSM.
  localparam int          LAT         = 14;
  localparam logic [1:0]  S_IDLE      = 2'b00;
  localparam logic [1:0]  S_RUN       = 2'b01;
  localparam logic [1:0]  S_PAUSE     = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic       btn_lap = 1'b0;
  logic       cnt_clr, sec_tick, lap_latch, disp_sel;
  logic [1:0] state;

  int         tests = 0;
  int         fails = 0;
  int         run_cnt = 0;
  bit         have_prev = 1'b0;
  logic [1:0] prev_st = S_IDLE;

  stopwatch_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_start (btn_start),
    .btn_pause (btn_pause),
    .btn_lap   (btn_lap),
    .cnt_clr   (cnt_clr),
    .sec_tick  (sec_tick),
    .lap_latch (lap_latch),
    .disp_sel  (disp_sel),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btns(input logic [2:0] m);
    {btn_start, btn_pause, btn_lap} = m;
  endtask

  task automatic release_btns();
    set_btns(3'b000);
    step(16);
  endtask

  task automatic wait_tick(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!sec_tick && k < 3 * CLK_HZ);
  endtask

  // Every tick must be preceded by exactly CLK_HZ cycles spent in RUN since the last tick or clear.
  always @(negedge clk) begin
    if (!rst_n) begin
      run_cnt   = 0;
      have_prev = 1'b0;
      prev_st   = S_IDLE;
    end else begin
      if (sec_tick) begin
        check("tick_from_run", {30'd0, prev_st}, {30'd0, S_RUN});
        if (have_prev) check("run_cycles_per_tick", run_cnt, CLK_HZ);
        run_cnt   = 0;
        have_prev = 1'b1;
      end
      if (cnt_clr) begin
        check("clr_exclusive", {30'd0, sec_tick, lap_latch}, 0);
        run_cnt   = 0;
        have_prev = 1'b1;
      end
      if (state == S_RUN) run_cnt++;
      prev_st = state;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n, k;
    logic seen;

    // Reset state
    step(3);
    check("rst_state", state, S_IDLE);
    check("rst_cnt_clr", cnt_clr, 0);
    check("rst_sec_tick", sec_tick, 0);
    check("rst_lap_latch", lap_latch, 0);
    check("rst_disp_sel", disp_sel, 0);
    rst_n = 1'b1;
    step(2);

    // Start from IDLE: one clear pulse, then ticks every CLK_HZ cycles
    btn_start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cnt_clr && n < 40);
    check("start_latency", n, LAT);
    check("start_state", state, S_RUN);
    check("start_disp", disp_sel, 0);
    step(1);
    check("clr_single_pulse", cnt_clr, 0);
    step(30 - n - 1);
    btn_start = 1'b0;
    wait_tick(k);
    check("first_tick", 30 - n + k, CLK_HZ);

    // Bouncing pause button never settles: no event, ticks keep their spacing
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) btn_pause = ~btn_pause;
      step(1);
    end
    btn_pause = 1'b0;
    step(20);
    check("bounce_state", state, S_RUN);
    wait_tick(k);
    check("tick_after_bounce", 60 + k, CLK_HZ);

    // Pause with prescaler at 4000, hold 50000 cycles, resume
    step(4000 - LAT);
    btn_pause = 1'b1;
    step(LAT);
    check("pause_state", state, S_PAUSE);
    seen = 1'b0;
    for (int i = 0; i < 50000 - LAT; i++) begin
      if (i == 16) btn_pause = 1'b0;
      step(1);
      seen = seen | sec_tick;
    end
    check("no_tick_in_pause", seen, 0);
    check("still_paused", state, S_PAUSE);
    btn_pause = 1'b1;
    step(LAT);
    check("resume_state", state, S_RUN);
    wait_tick(k);
    check("tick_after_resume", k, CLK_HZ - 4000);
    btn_pause = 1'b0;
    step(16);

    // Lap toggling in RUN
    btn_lap = 1'b1;
    step(LAT);
    check("lap1_latch", lap_latch, 1);
    check("lap1_disp", disp_sel, 1);
    check("lap1_no_clr", cnt_clr, 0);
    step(1);
    check("lap1_single_pulse", lap_latch, 0);
    release_btns();
    btn_lap = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      step(1);
      seen = seen | lap_latch;
    end
    check("lap2_no_latch", seen, 0);
    check("lap2_disp", disp_sel, 0);
    release_btns();
    btn_lap = 1'b1;
    step(LAT);
    check("lap3_disp", disp_sel, 1);
    release_btns();

    // Simultaneous start+pause+lap while showing lap: only the clear survives
    set_btns(3'b111);
    step(LAT);
    check("sim_clr", cnt_clr, 1);
    check("sim_no_latch", lap_latch, 0);
    check("sim_state", state, S_RUN);
    check("sim_disp", disp_sel, 0);
    step(20);
    check("sim_pause_dropped", state, S_RUN);
    release_btns();

    // Lap in PAUSE only unfreezes, then start from PAUSE returns to IDLE
    btn_lap = 1'b1;
    step(LAT);
    check("lap4_disp", disp_sel, 1);
    release_btns();
    btn_pause = 1'b1;
    step(LAT);
    check("pause2_state", state, S_PAUSE);
    release_btns();
    btn_lap = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      step(1);
      seen = seen | lap_latch;
    end
    check("pause_lap_no_latch", seen, 0);
    check("pause_lap_disp", disp_sel, 0);
    release_btns();
    btn_start = 1'b1;
    step(LAT);
    check("pause_start_state", state, S_IDLE);
    check("pause_start_clr", cnt_clr, 1);
    release_btns();

    // IDLE ignores pause and lap
    set_btns(3'b011);
    step(LAT + 2);
    check("idle_ignore_state", state, S_IDLE);
    check("idle_ignore_disp", disp_sel, 0);
    release_btns();

    // Async reset mid-run with lap frozen
    btn_start = 1'b1;
    step(LAT);
    check("run2_state", state, S_RUN);
    release_btns();
    btn_lap = 1'b1;
    step(LAT);
    check("run2_disp", disp_sel, 1);
    release_btns();
    step($urandom_range(500, 5000));
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", state, S_IDLE);
    check("arst_disp", disp_sel, 0);
    check("arst_cnt_clr", cnt_clr, 0);
    check("arst_sec_tick", sec_tick, 0);
    check("arst_lap_latch", lap_latch, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      seen = seen | sec_tick | cnt_clr;
    end
    check("no_tick_after_reset", seen, 0);
    check("idle_after_reset", state, S_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
